// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - state encoding, reset-cause codes and sizing helper for board_rst_seq
package board_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_PERIPH    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_FPGA = 2'd1;
    localparam logic [1:0] CAUSE_MCU  = 2'd2;
    localparam logic [1:0] CAUSE_LOCK = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/board_deb_sync.sv
// rtl/board_deb_sync.sv - 2-flop synchronizer followed by a saturating debounce counter
module board_deb_sync #(
    parameter int   DEB_CNT = 16000,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    localparam int CW = $clog2(DEB_CNT) + 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {2{RST_VAL}};
            cnt  <= '0;
            deb  <= RST_VAL;
        end else begin
            sync <= {sync[0], raw};
            // Any sample agreeing with the current output restarts the stability window.
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt >= CW'(DEB_CNT - 1)) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_rst_seq.sv
// rtl/board_rst_seq.sv - board reset sequencer; BOARD_RST_SEQ_WAKEUP_DEB_EN adds wakeup debounce
module board_rst_seq
    import board_pkg::*;
#(
    parameter int DEB_CNT    = 16000,
    parameter int LOCK_HOLD  = 256,
    parameter int PERIPH_GAP = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fpga_rst_raw_n,
    input  logic       mcu_rst_raw_n,
    input  logic       mmcm_locked,
    input  logic       wakeup_raw,
    output logic       periph_rst,
    output logic       core_rst_n,
    output logic       erst_n,
    output logic       dwakeup_n,
    output logic [1:0] state_o,
    output logic [1:0] rst_cause
);

    localparam int CNT_W = $clog2(max3(DEB_CNT, LOCK_HOLD, PERIPH_GAP)) + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lock_sync;
    logic             locked;
    logic             fpga_deb;
    logic             mcu_deb;
    logic             hold_req;
    logic [1:0]       hold_cause;

    board_deb_sync #(.DEB_CNT(DEB_CNT), .RST_VAL(1'b0)) u_fpga_deb (
        .clk(clk), .rst_n(rst_n), .raw(fpga_rst_raw_n), .deb(fpga_deb)
    );

    board_deb_sync #(.DEB_CNT(DEB_CNT), .RST_VAL(1'b0)) u_mcu_deb (
        .clk(clk), .rst_n(rst_n), .raw(mcu_rst_raw_n), .deb(mcu_deb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_sync <= 2'b00;
        else        lock_sync <= {lock_sync[0], mmcm_locked};
    end
    assign locked = lock_sync[1];

    // Priority order fpga > mcu > lock; lock loss only matters once the clock was qualified.
    always_comb begin
        hold_req   = 1'b0;
        hold_cause = CAUSE_POR;
        if (state != ST_HOLD) begin
            if (!fpga_deb) begin
                hold_req   = 1'b1;
                hold_cause = CAUSE_FPGA;
            end else if (!mcu_deb) begin
                hold_req   = 1'b1;
                hold_cause = CAUSE_MCU;
            end else if (!locked && state != ST_WAIT_LOCK) begin
                hold_req   = 1'b1;
                hold_cause = CAUSE_LOCK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            periph_rst <= 1'b1;
            core_rst_n <= 1'b0;
            erst_n     <= 1'b0;
            rst_cause  <= CAUSE_POR;
        end else if (hold_req) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            periph_rst <= 1'b1;
            core_rst_n <= 1'b0;
            erst_n     <= 1'b0;
            rst_cause  <= hold_cause;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (fpga_deb && mcu_deb) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!locked) begin
                        cnt <= '0;
                    end else if (cnt >= CNT_W'(LOCK_HOLD - 1)) begin
                        state      <= ST_PERIPH;
                        cnt        <= '0;
                        periph_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PERIPH: begin
                    if (cnt >= CNT_W'(PERIPH_GAP - 1)) begin
                        state      <= ST_RUN;
                        cnt        <= '0;
                        core_rst_n <= 1'b1;
                        erst_n     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: state <= ST_HOLD;
            endcase
        end
    end

    assign state_o = state;

`ifdef BOARD_RST_SEQ_WAKEUP_DEB_EN
    logic wake_deb;

    board_deb_sync #(.DEB_CNT(DEB_CNT), .RST_VAL(1'b0)) u_wake_deb (
        .clk(clk), .rst_n(rst_n), .raw(wakeup_raw), .deb(wake_deb)
    );
    assign dwakeup_n = ~wake_deb;
`else
    logic wake_s1;

    // Second synchronizer stage is the inverted output flop itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wake_s1   <= 1'b0;
            dwakeup_n <= 1'b1;
        end else begin
            wake_s1   <= wakeup_raw;
            dwakeup_n <= ~wake_s1;
        end
    end
`endif

endmodule
